// File: rtl/cell_plotter_if.sv
// cell_plotter_if: command and pixel-port bundle between the game
// controller (master), the cell plotter (slave) and the VGA adapter
// write port. The clock and reset stay plain module ports.
interface cell_plotter_if;
  // Command side: one playfield cell per accepted start
  logic       start;
  logic [3:0] col;
  logic [4:0] row;
  logic [5:0] colour_in;

  // Status back to the controller
  logic       busy;
  logic       done;
  logic       err;

  // Adapter pixel write port, registered together
  logic [7:0] x;
  logic [6:0] y;
  logic [5:0] colour;
  logic       plot;

  // Controller view: issues commands, watches status and the pixel port
  modport master (
    output start, col, row, colour_in,
    input  busy, done, err, x, y, colour, plot
  );

  // Plotter view: consumes commands, drives status and the pixel port
  modport slave (
    input  start, col, row, colour_in,
    output busy, done, err, x, y, colour, plot
  );
endinterface

// File: rtl/cell_plotter.sv
// cell_plotter: sweeps one Tetris playfield cell (CELL x CELL pixels)
// into the 160x120 VGA adapter framebuffer, one pixel per clock, in
// raster order (dx fastest). Out-of-range commands raise a one-cycle err.
// Optional feature macro: CELL_PLOTTER_BORDER_EN darkens the outer ring
// of each cell (each 2-bit channel shifted right by one).
module cell_plotter #(
  parameter int CELL      = 5,
  parameter int ORIGIN_X  = 55,
  parameter int ORIGIN_Y  = 10,
  parameter int GRID_COLS = 10,
  parameter int GRID_ROWS = 20
) (
  input  logic           clk,
  input  logic           reset_n,
  cell_plotter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAW,
    S_DONE
  } state_t;

  localparam logic [2:0] LAST    = 3'(CELL - 1);
  localparam logic [8:0] ORG_X9  = 9'(ORIGIN_X);
  localparam logic [8:0] ORG_Y9  = 9'(ORIGIN_Y);
  localparam logic [8:0] CELL9   = 9'(CELL);
  localparam logic [7:0] COLS_LIM = 8'(GRID_COLS);
  localparam logic [7:0] ROWS_LIM = 8'(GRID_ROWS);

  state_t     state;
  state_t     state_nx;

  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [5:0] colour_q;
  logic [2:0] dx;
  logic [2:0] dy;

  logic       in_range;
  logic       accept;
  logic       reject;
  logic       reject_q;
  logic       last_pixel;
  logic [8:0] sum_x;
  logic [8:0] sum_y;
  logic [5:0] pix_colour;
  logic       unused_sum_bits;

  // Command decode: range check, base-address sums and accept/reject
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned; that is what keeps latches from being inferred.
    in_range   = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    sum_x      = ORG_X9 + 9'(bus.col) * CELL9;
    sum_y      = ORG_Y9 + 9'(bus.row) * CELL9;
    last_pixel = (dx == LAST) && (dy == LAST);

    in_range = ({4'd0, bus.col} < COLS_LIM) && ({3'd0, bus.row} < ROWS_LIM);
    if (state == S_IDLE && bus.start) begin
      accept = in_range;
      reject = !in_range;
    end
  end

  // Legal parameter sets keep the sums inside the framebuffer, so the
  // carry bits beyond the port widths are never set.
  assign unused_sum_bits = ^{sum_x[8], sum_y[8:7]};

  // FSM next-state: IDLE -> DRAW on accept, DRAW -> DONE after last pixel
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_DRAW;
      S_DRAW:  if (last_pixel) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

`ifdef CELL_PLOTTER_BORDER_EN
  logic on_border;

  // Border ring pixels get each colour channel halved
  always_comb begin
    on_border  = (dx == 3'd0) || (dx == LAST) || (dy == 3'd0) || (dy == LAST);
    pix_colour = colour_q;
    if (on_border)
      pix_colour = {1'b0, colour_q[5], 1'b0, colour_q[3], 1'b0, colour_q[1]};
  end
`else
  // Whole cell uses the latched colour unchanged
  always_comb pix_colour = colour_q;
`endif

  // FSM state register; async reset returns to IDLE without a clock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Command latch and raster counters (dx fastest, dy on dx wrap)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_x   <= '0;
      base_y   <= '0;
      colour_q <= '0;
      dx       <= '0;
      dy       <= '0;
    end else if (accept) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      base_x   <= sum_x[7:0];
      base_y   <= sum_y[6:0];
      colour_q <= bus.colour_in;
      dx       <= '0;
      dy       <= '0;
    end else if (state == S_DRAW) begin
      if (dx == LAST) begin
        dx <= '0;
        dy <= dy + 3'd1;
      end else begin
        dx <= dx + 3'd1;
      end
    end
  end

  // Registered adapter port and status pulses; err lags the rejecting edge by one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.x      <= '0;
      bus.y      <= '0;
      bus.colour <= '0;
      bus.plot   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.err    <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      if (state == S_DRAW) begin
        bus.x      <= base_x + {5'd0, dx};
        bus.y      <= base_y + {4'd0, dy};
        bus.colour <= pix_colour;
      end
      bus.plot <= (state == S_DRAW);
      bus.busy <= (state == S_DRAW);
      bus.done <= (state == S_DONE);
      reject_q <= reject;
      bus.err  <= reject_q;
    end
  end

endmodule

// File: tb/tb_cell_plotter.sv
// tb_cell_plotter: directed and randomized cell commands against a
// pixel-list reference model derived from the cell geometry.
module tb_cell_plotter;
  localparam int CELL      = 5;
  localparam int ORIGIN_X  = 55;
  localparam int ORIGIN_Y  = 10;
  localparam int NPIX      = CELL * CELL;
`ifdef CELL_PLOTTER_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  cell_plotter_if bus ();

  cell_plotter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected colour of pixel (px, py) of a cell painted with c
  function automatic logic [31:0] exp_colour(input logic [5:0] c, input int px, input int py);
    int r, g, b;
    r = int'(c[5:4]);
    g = int'(c[3:2]);
    b = int'(c[1:0]);
    if (BORDER && (px == 0 || px == CELL - 1 || py == 0 || py == CELL - 1)) begin
      r = r / 2;
      g = g / 2;
      b = b / 2;
    end
    return 32'(r * 16 + g * 4 + b);
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, " plot"}, 32'(bus.plot), 0);
    check({tag, " busy"}, 32'(bus.busy), 0);
    check({tag, " done"}, 32'(bus.done), 0);
  endtask

  // One accepted command; optionally pulses a second start mid-draw
  task automatic run_cell(input int c, input int r, input logic [5:0] cl, input bit poke);
    int dones;
    dones = 0;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.col       = 4'(c);
    bus.row       = 5'(r);
    bus.colour_in = cl;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.col       = 4'($urandom);
    bus.row       = 5'($urandom);
    bus.colour_in = 6'($urandom);
    check_quiet("accept");
    for (int k = 1; k <= NPIX + 1; k++) begin
      if (poke && k == 3) begin
        bus.start = 1'b1;
        bus.col   = 4'd5;
        bus.row   = 5'd4;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      dones += int'(bus.done);
      if (k <= NPIX) begin
        check($sformatf("plot k=%0d", k), 32'(bus.plot), 1);
        check($sformatf("busy k=%0d", k), 32'(bus.busy), 1);
        check($sformatf("done k=%0d", k), 32'(bus.done), 0);
        check($sformatf("x k=%0d", k), 32'(bus.x),
              32'(ORIGIN_X + c * CELL + (k - 1) % CELL));
        check($sformatf("y k=%0d", k), 32'(bus.y),
              32'(ORIGIN_Y + r * CELL + (k - 1) / CELL));
        check($sformatf("colour k=%0d", k), 32'(bus.colour),
              exp_colour(cl, (k - 1) % CELL, (k - 1) / CELL));
      end else begin
        check("done pulse", 32'(bus.done), 1);
        check("plot at done", 32'(bus.plot), 0);
        check("busy at done", 32'(bus.busy), 0);
      end
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    dones += int'(bus.done);
    check_quiet("after done");
    check("done count", 32'(dones), 1);
  endtask

  // One rejected command: err at t+1 only, nothing drawn
  task automatic run_reject(input int c, input int r);
    @(negedge clk);
    bus.start = 1'b1;
    bus.col   = 4'(c);
    bus.row   = 5'(r);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("rej err k=0", 32'(bus.err), 0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("rej err k=%0d", k), 32'(bus.err), (k == 1) ? 1 : 0);
      check_quiet("rej");
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.col       = '0;
    bus.row       = '0;
    bus.colour_in = '0;
    reset_n       = 1'b0;
    #1;
    check("rst x", 32'(bus.x), 0);
    check("rst y", 32'(bus.y), 0);
    check("rst colour", 32'(bus.colour), 0);
    check("rst err", 32'(bus.err), 0);
    check_quiet("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Top-left cell, then bottom-right corner cell
    run_cell(0, 0, 6'h30, 1'b0);
    run_cell(9, 19, 6'h0C, 1'b0);

    // Out-of-range column and row
    run_reject(10, 0);
    run_reject(0, 20);

    // Second start while busy is ignored
    run_cell(3, 4, 6'h21, 1'b1);

    // Full-white cell exercises the border darkening when enabled
    run_cell(4, 8, 6'h3F, 1'b0);

    // Reset during the 8th plot cycle
    @(negedge clk);
    bus.start     = 1'b1;
    bus.col       = 4'd2;
    bus.row       = 5'd7;
    bus.colour_in = 6'h2A;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 8; k++) @(posedge clk);
    #1;
    check("pre-reset plot", 32'(bus.plot), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid-reset x", 32'(bus.x), 0);
    check("mid-reset y", 32'(bus.y), 0);
    check("mid-reset colour", 32'(bus.colour), 0);
    check("mid-reset err", 32'(bus.err), 0);
    check_quiet("mid-reset");
    repeat (2) begin
      @(posedge clk); #1;
      check_quiet("held reset");
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check_quiet("post reset");
    end
    run_cell(6, 11, 6'h15, 1'b0);

    // Randomized legal and illegal commands
    for (int i = 0; i < 6; i++) begin
      run_cell(int'($urandom_range(0, 9)), int'($urandom_range(0, 19)),
               6'($urandom), 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 1) == 0)
        run_reject(int'($urandom_range(10, 15)), int'($urandom_range(0, 19)));
      else
        run_reject(int'($urandom_range(0, 9)), int'($urandom_range(20, 31)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
